// File: rtl/iob_gpio_sseg_scan_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner.
package iob_gpio_sseg_scan_pkg;

    localparam int unsigned SSEG_CA_W = 8;

    // Hex digit to segment table, gfedcba, 1 = lit; entry [n] is the glyph for nibble n.
    localparam logic [15:0][6:0] SSEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {
        SSEG_IDLE  = 2'd0,
        SSEG_DEAD  = 2'd1,
        SSEG_DRIVE = 2'd2
    } sseg_state_e;

endpackage

// File: rtl/iob_gpio_sseg_scan_hex_dec.sv
// Nibble plus decimal point to active-high segment pattern.
module iob_gpio_sseg_scan_hex_dec
    import iob_gpio_sseg_scan_pkg::*;
(
    input  logic [3:0]           nibble_i,
    input  logic                 dp_i,
    output logic [SSEG_CA_W-1:0] seg_o
);

    // Table lookup; polarity is applied later at the output register.
    assign seg_o = {dp_i, SSEG_HEX[nibble_i]};

endmodule

// File: rtl/iob_gpio_sseg_scan.sv
// Multiplexed seven-segment driver: entry registers, slot/index scan FSM, registered pins.
module iob_gpio_sseg_scan
    import iob_gpio_sseg_scan_pkg::*;
#(
    parameter int unsigned N_DIGITS   = 8,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned DEAD_CYC   = 4,
    parameter bit          AN_ACT_LOW = 1'b1,
    parameter bit          CA_ACT_LOW = 1'b1,
    localparam int unsigned AW        = $clog2(N_DIGITS)
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 cfg_en,
    input  logic                 cfg_raw,
    input  logic [DIV_W-1:0]     scan_div,
    input  logic [N_DIGITS-1:0]  blank_mask,
    input  logic                 digit_wr,
    input  logic [AW-1:0]        digit_addr,
    input  logic [7:0]           digit_wdata,
    output logic [SSEG_CA_W-1:0] sseg_ca,
    output logic [N_DIGITS-1:0]  sseg_an,
    output logic                 frame_tick
);

    localparam logic [N_DIGITS-1:0]  AN_OFF  = AN_ACT_LOW ? '1 : '0;
    localparam logic [SSEG_CA_W-1:0] CA_OFF  = CA_ACT_LOW ? '1 : '0;
    localparam logic [AW-1:0]        IDX_MAX = AW'(N_DIGITS - 1);
    localparam logic [DIV_W-1:0]     DEAD_END = DIV_W'(DEAD_CYC);
    localparam sseg_state_e          SLOT_START = (DEAD_CYC == 0) ? SSEG_DRIVE : SSEG_DEAD;

    sseg_state_e           state_q, state_d;
    logic [DIV_W-1:0]      cnt_q, cnt_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [7:0]            entry_q [N_DIGITS];
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [SSEG_CA_W-1:0]  ca_q, ca_d;
    logic                  tick_q;
    logic                  wrap_c;
    logic [DIV_W-1:0]      cnt_inc_c;
    logic [7:0]            cur_entry_c;
    logic [SSEG_CA_W-1:0]  hex_seg_c;
    logic [SSEG_CA_W-1:0]  seg_c;
    logic [N_DIGITS-1:0]   onehot_c;
    logic                  drive_c;

    // Entry storage; addresses with no matching digit are dropped.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < int'(N_DIGITS); i++) entry_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(N_DIGITS); i++) begin
                if (digit_wr && (digit_addr == AW'(i))) entry_q[i] <= digit_wdata;
            end
        end
    end

    // Scan state, slot counter, digit index and pin registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= SSEG_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= AN_OFF;
            ca_q    <= CA_OFF;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            ca_q    <= ca_d;
            tick_q  <= wrap_c;
        end
    end

    assign cnt_inc_c = cnt_q + DIV_W'(1);

    // Next state: slot end wins over the dead-to-drive hand-off.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wrap_c  = 1'b0;
        if (!cfg_en) begin
            state_d = SSEG_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                SSEG_IDLE: begin
                    state_d = SLOT_START;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                SSEG_DEAD, SSEG_DRIVE: begin
                    if (cnt_q == scan_div) begin
                        cnt_d   = '0;
                        state_d = SLOT_START;
                        if (idx_q == IDX_MAX) begin
                            idx_d  = '0;
                            wrap_c = 1'b1;
                        end else begin
                            idx_d = idx_q + AW'(1);
                        end
                    end else begin
                        cnt_d = cnt_inc_c;
                        if (state_q == SSEG_DEAD && cnt_inc_c == DEAD_END) state_d = SSEG_DRIVE;
                    end
                end
                default: begin
                    state_d = SSEG_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    assign cur_entry_c = entry_q[idx_q];

    iob_gpio_sseg_scan_hex_dec u_hex_dec (
        .nibble_i (cur_entry_c[3:0]),
        .dp_i     (cur_entry_c[4]),
        .seg_o    (hex_seg_c)
    );

    // Pin values for the next cycle, from the current state and index.
    always_comb begin
        an_d     = AN_OFF;
        ca_d     = CA_OFF;
        onehot_c = N_DIGITS'(1) << idx_q;
        seg_c    = cfg_raw ? cur_entry_c : hex_seg_c;
        drive_c  = (state_q == SSEG_DRIVE) && !blank_mask[idx_q];
        if (drive_c) begin
            an_d = AN_ACT_LOW ? ~onehot_c : onehot_c;
            ca_d = CA_ACT_LOW ? ~seg_c : seg_c;
        end
    end

    assign sseg_an    = an_q;
    assign sseg_ca    = ca_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_iob_gpio_sseg_scan.sv
// Directed bench for the seven-segment scanner: per-cycle vector tables plus corner sequences.
module tb_iob_gpio_sseg_scan;

    logic        clk;
    logic        arst_n;
    logic        cfg_en, cfg_raw;
    logic [15:0] scan_div;
    logic [7:0]  blank_mask;
    logic        digit_wr;
    logic [2:0]  digit_addr;
    logic [7:0]  digit_wdata;
    logic [7:0]  sseg_ca, sseg_an;
    logic        frame_tick;

    // Second instance with a non power-of-two digit count for out-of-range writes.
    logic        en6, wr6;
    logic [2:0]  addr6;
    logic [7:0]  wdata6;
    logic [7:0]  ca6;
    logic [5:0]  an6;
    logic        tick6;

    typedef struct {
        int         k;
        logic [7:0] an;
        logic [7:0] ca;
        logic       tick;
    } vec_t;

    vec_t       vec[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         ticks;
    logic [7:0] an_seen;

    iob_gpio_sseg_scan dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .cfg_en      (cfg_en),
        .cfg_raw     (cfg_raw),
        .scan_div    (scan_div),
        .blank_mask  (blank_mask),
        .digit_wr    (digit_wr),
        .digit_addr  (digit_addr),
        .digit_wdata (digit_wdata),
        .sseg_ca     (sseg_ca),
        .sseg_an     (sseg_an),
        .frame_tick  (frame_tick)
    );

    iob_gpio_sseg_scan #(.N_DIGITS(6), .DEAD_CYC(0)) dut6 (
        .clk         (clk),
        .arst_n      (arst_n),
        .cfg_en      (en6),
        .cfg_raw     (1'b0),
        .scan_div    (16'd0),
        .blank_mask  (6'd0),
        .digit_wr    (wr6),
        .digit_addr  (addr6),
        .digit_wdata (wdata6),
        .sseg_ca     (ca6),
        .sseg_an     (an6),
        .frame_tick  (tick6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        digit_wr    = 1'b1;
        digit_addr  = a;
        digit_wdata = d;
        step();
        digit_wr    = 1'b0;
    endtask

    task automatic wr6_task(input logic [2:0] a, input logic [7:0] d);
        wr6    = 1'b1;
        addr6  = a;
        wdata6 = d;
        step();
        wr6    = 1'b0;
    endtask

    function automatic void add(input int k, input logic [7:0] an, input logic [7:0] ca, input logic tick);
        vec_t v;
        v.k = k; v.an = an; v.ca = ca; v.tick = tick;
        vec.push_back(v);
    endfunction

    task automatic disable_scan();
        cfg_en = 1'b0;
        step();
        step();
    endtask

    // Enable the scan and compare the pins at the table's sample indices (k = edges since enable).
    task automatic play(input string tag);
        int k;
        k       = 0;
        ticks   = 0;
        an_seen = '0;
        cfg_en  = 1'b1;
        for (int i = 0; i < vec.size(); i++) begin
            while (k < vec[i].k) begin
                step();
                k++;
                ticks   += int'(frame_tick);
                an_seen |= ~sseg_an;
            end
            chk($sformatf("%s an k=%0d", tag, k), 32'(sseg_an), 32'(vec[i].an));
            chk($sformatf("%s ca k=%0d", tag, k), 32'(sseg_ca), 32'(vec[i].ca));
            chk($sformatf("%s tick k=%0d", tag, k), 32'(frame_tick), 32'(vec[i].tick));
        end
        vec.delete();
    endtask

    initial begin
        arst_n = 1'b1; cfg_en = 1'b0; cfg_raw = 1'b0; scan_div = 16'd9;
        blank_mask = 8'h00; digit_wr = 1'b0; digit_addr = '0; digit_wdata = '0;
        en6 = 1'b0; wr6 = 1'b0; addr6 = '0; wdata6 = '0;

        // Reset values, asserted before any clock edge.
        #1 arst_n = 1'b0;
        #2;
        chk("rst an", 32'(sseg_an), 32'h00FF);
        chk("rst ca", 32'(sseg_ca), 32'h00FF);
        chk("rst tick", 32'(frame_tick), 32'h0);
        chk("rst an6", 32'(an6), 32'h003F);
        repeat (3) step();
        arst_n = 1'b1;
        repeat (4) step();
        chk("idle an", 32'(sseg_an), 32'h00FF);
        chk("idle ca", 32'(sseg_ca), 32'h00FF);

        // Hex scan, slot = 10 cycles, 4 dead.
        wr(3'd0, 8'h13);
        wr(3'd1, 8'h08);
        add(1, 8'hFF, 8'hFF, 0);   add(5, 8'hFF, 8'hFF, 0);
        add(6, 8'hFE, 8'h30, 0);   add(11, 8'hFE, 8'h30, 0);
        add(12, 8'hFF, 8'hFF, 0);  add(15, 8'hFF, 8'hFF, 0);
        add(16, 8'hFD, 8'h80, 0);  add(21, 8'hFD, 8'h80, 0);
        add(22, 8'hFF, 8'hFF, 0);  add(26, 8'hFB, 8'hC0, 0);
        add(76, 8'h7F, 8'hC0, 0);  add(80, 8'h7F, 8'hC0, 0);
        add(81, 8'h7F, 8'hC0, 1);  add(82, 8'hFF, 8'hFF, 0);
        add(86, 8'hFE, 8'h30, 0);  add(161, 8'h7F, 8'hC0, 1);
        play("hex");
        chk("hex ticks", 32'(ticks), 32'd2);

        // Raw mode with digit 2 blanked.
        disable_scan();
        cfg_raw = 1'b1;
        wr(3'd2, 8'h81);
        blank_mask = 8'h04;
        add(6, 8'hFE, 8'hEC, 0);   add(16, 8'hFD, 8'hF7, 0);
        add(26, 8'hFF, 8'hFF, 0);  add(36, 8'hF7, 8'hFF, 0);
        add(81, 8'h7F, 8'hFF, 1);
        play("blank");
        chk("blank an_seen", 32'(an_seen), 32'h00FB);

        // Mask cleared: digit 2 shows raw pattern.
        disable_scan();
        blank_mask = 8'h00;
        add(21, 8'hFD, 8'hF7, 0);  add(26, 8'hFB, 8'h7E, 0);
        play("raw");

        // Disable in DRIVE: one cycle of latency, then dark; restart at digit 0 with a dead phase.
        cfg_en = 1'b0;
        step();
        chk("dis lat an", 32'(sseg_an), 32'h00FB);
        step();
        chk("dis an", 32'(sseg_an), 32'h00FF);
        chk("dis ca", 32'(sseg_ca), 32'h00FF);
        add(2, 8'hFF, 8'hFF, 0);   add(5, 8'hFF, 8'hFF, 0);
        add(6, 8'hFE, 8'hEC, 0);   add(7, 8'hFE, 8'hEC, 0);
        play("reen");

        // Asynchronous reset while driving digit 0.
        #2 arst_n = 1'b0;
        #1;
        chk("arst an", 32'(sseg_an), 32'h00FF);
        chk("arst ca", 32'(sseg_ca), 32'h00FF);
        chk("arst tick", 32'(frame_tick), 32'h0);
        @(negedge clk);
        cfg_en = 1'b0; cfg_raw = 1'b0; arst_n = 1'b1;
        step();
        add(6, 8'hFE, 8'hC0, 0);   add(16, 8'hFD, 8'hC0, 0);
        play("postrst");

        // Write to the digit being driven: new glyph two edges after the strobe.
        digit_wr = 1'b1; digit_addr = 3'd1; digit_wdata = 8'h05;
        step();
        digit_wr = 1'b0;
        chk("wr lat1 an", 32'(sseg_an), 32'h00FD);
        chk("wr lat1 ca", 32'(sseg_ca), 32'h00C0);
        step();
        chk("wr lat2 an", 32'(sseg_an), 32'h00FD);
        chk("wr lat2 ca", 32'(sseg_ca), 32'h0092);

        // Slot shorter than the dead time: always dark, index still wraps.
        disable_scan();
        scan_div = 16'd2;
        add(3, 8'hFF, 8'hFF, 0);   add(24, 8'hFF, 8'hFF, 0);
        add(25, 8'hFF, 8'hFF, 1);  add(26, 8'hFF, 8'hFF, 0);
        add(49, 8'hFF, 8'hFF, 1);  add(73, 8'hFF, 8'hFF, 1);
        add(97, 8'hFF, 8'hFF, 1);
        play("short");
        chk("short ticks", 32'(ticks), 32'd4);
        chk("short an_seen", 32'(an_seen), 32'h0);
        cfg_en = 1'b0;

        // Six-digit instance: writes to addresses 6 and 7 must not land anywhere.
        wr6_task(3'd6, 8'h08);
        wr6_task(3'd7, 8'h08);
        wr6_task(3'd5, 8'h01);
        en6 = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            logic [5:0] exp_an;
            logic [7:0] exp_ca;
            logic       exp_tk;
            int         d;
            step();
            d = (k - 2) % 6;
            if (k == 1) begin
                exp_an = 6'h3F; exp_ca = 8'hFF; exp_tk = 1'b0;
            end else begin
                exp_an = ~(6'h01 << d);
                exp_ca = (d == 5) ? 8'hF9 : 8'hC0;
                exp_tk = (k == 7 || k == 13);
            end
            chk($sformatf("n6 an k=%0d", k), 32'(an6), 32'(exp_an));
            chk($sformatf("n6 ca k=%0d", k), 32'(ca6), 32'(exp_ca));
            chk($sformatf("n6 tick k=%0d", k), 32'(tick6), 32'(exp_tk));
        end
        en6 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
